// File: rtl/nios2_mul_pkg.sv
// nios2_mul_pkg: shared types and constants for the Nios II multiply sequencer.
// Configuration macro: NIOS2_MUL_HIGH_EN (defined = high-word ops, 64-bit
// accumulator; undefined = low-word only, 32-bit accumulator).
package nios2_mul_pkg;

  localparam int HALF_W = 16;

`ifdef NIOS2_MUL_HIGH_EN
  localparam int ACC_W = 64;
`else
  localparam int ACC_W = 32;
`endif

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULXSS = 2'b01,
    MULXSU = 2'b10,
    MULXUU = 2'b11
  } mul_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    CORR  = 3'd3,
    DONE  = 3'd4
  } mul_state_t;

  // Shift code carried alongside each partial product through the cell latency.
  typedef logic [1:0] shift_t;
  localparam shift_t SH_0  = 2'd0;
  localparam shift_t SH_16 = 2'd1;
  localparam shift_t SH_32 = 2'd2;

  // Place a 32-bit partial product at its weight inside the accumulator.
  function automatic logic [ACC_W-1:0] align_pp(input logic [2*HALF_W-1:0] p,
                                                input shift_t sh);
    logic [ACC_W-1:0] w;
    w = ACC_W'(p);
    case (sh)
      SH_16: w = w << HALF_W;
`ifdef NIOS2_MUL_HIGH_EN
      SH_32: w = w << (2 * HALF_W);
`endif
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/nios2_mul_half_cell.sv
// nios2_mul_half_cell: registered 16x16 unsigned multiplier, LAT stages deep.
// Ports:
//   i_clk, i_reset_n : clock, async active-low clear of all stages
//   i_en             : stage enable; low holds every stage
//   i_a, i_b         : 16-bit unsigned operands
//   o_p              : 32-bit product, valid LAT enabled cycles after issue
module nios2_mul_half_cell
  import nios2_mul_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic [HALF_W-1:0]     i_a,
  input  logic [HALF_W-1:0]     i_b,
  output logic [2*HALF_W-1:0]   o_p
);

  logic [2*HALF_W-1:0] r_pipe [LAT];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else if (i_en) begin
      r_pipe[0] <= (2*HALF_W)'(i_a) * (2*HALF_W)'(i_b);
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_p = r_pipe[LAT-1];

endmodule

// File: rtl/nios2_mul_seq.sv
// nios2_mul_seq: multi-cycle 32x32 multiply built from one 16x16 cell.
// Configuration macro: NIOS2_MUL_HIGH_EN enables MULXSS/MULXSU/MULXUU (P3,
// signed correction, 64-bit accumulator). Without it every op runs as MUL.
// Ports:
//   i_clk, i_reset_n   : clock, async active-low reset
//   i_en               : pipeline enable; low freezes sequencer and cell
//   i_start            : request, accepted when i_en and not busy
//   i_op               : 00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
//   i_src1, i_src2     : operands A and B, sampled at accept
//   o_busy, o_done     : handshake; o_done is a one-cycle pulse
//   o_result           : product word, held until the next accept
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one partial product into the cell per enabled cycle
// DRAIN | wait LAT cycles for in-flight products to land in the accumulator
// CORR  | signed correction of the high word (MULX only)
// DONE  | result valid, done pulsed; accepts a new start like IDLE
module nios2_mul_seq
  import nios2_mul_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  mul_state_t       r_state;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [1:0]       r_idx;
  logic [1:0]       r_drain;
  logic [ACC_W-1:0] r_acc;
  logic             r_tag_v  [LAT];
  shift_t           r_tag_sh [LAT];

  logic [HALF_W-1:0]   w_op_a;
  logic [HALF_W-1:0]   w_op_b;
  shift_t              w_shift;
  logic [2*HALF_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_acc_next;
  logic [1:0]          w_last_idx;
  logic                w_issue;

  assign w_issue = (r_state == ISSUE);

  always_comb begin
    w_op_a  = r_a[15:0];
    w_op_b  = r_b[15:0];
    w_shift = SH_0;
    case (r_idx)
      2'd1: begin w_op_b = r_b[31:16]; w_shift = SH_16; end
      2'd2: begin w_op_a = r_a[31:16]; w_shift = SH_16; end
      2'd3: begin w_op_a = r_a[31:16]; w_op_b = r_b[31:16]; w_shift = SH_32; end
      default: ;
    endcase
  end

  nios2_mul_half_cell #(.LAT(LAT)) u_cell (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (i_en),
    .i_a       (w_op_a),
    .i_b       (w_op_b),
    .o_p       (w_prod)
  );

  // The product leaving the cell is folded in on the same edge the sequencer
  // may finish, so the completion path registers the already-summed value.
  assign w_acc_next = r_acc + (r_tag_v[LAT-1] ? align_pp(w_prod, r_tag_sh[LAT-1])
                                              : '0);

`ifdef NIOS2_MUL_HIGH_EN
  mul_op_t     r_op;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_hi;

  assign w_last_idx = (r_op == MUL) ? 2'd2 : 2'd3;
  assign w_sign_a   = r_a[31] & ((r_op == MULXSS) || (r_op == MULXSU));
  assign w_sign_b   = r_b[31] & (r_op == MULXSS);
  assign w_hi       = r_acc[63:32] - (w_sign_a ? r_b : 32'd0)
                                   - (w_sign_b ? r_a : 32'd0);
`else
  logic w_unused_op;
  assign w_last_idx  = 2'd2;
  assign w_unused_op = ^i_op;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_drain  <= '0;
      r_acc    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_tag_v[i]  <= 1'b0;
        r_tag_sh[i] <= SH_0;
      end
`ifdef NIOS2_MUL_HIGH_EN
      r_op     <= MUL;
`endif
    end else begin
      // done is a pulse even if en drops in the completion cycle
      o_done <= 1'b0;
      if (i_en) begin
        r_acc       <= w_acc_next;
        r_tag_v[0]  <= w_issue;
        r_tag_sh[0] <= w_shift;
        for (int i = 1; i < LAT; i++) begin
          r_tag_v[i]  <= r_tag_v[i-1];
          r_tag_sh[i] <= r_tag_sh[i-1];
        end
        case (r_state)
          IDLE, DONE: begin
            if (i_start) begin
              r_a     <= i_src1;
              r_b     <= i_src2;
              r_acc   <= '0;
              r_idx   <= 2'd0;
              o_busy  <= 1'b1;
              r_state <= ISSUE;
`ifdef NIOS2_MUL_HIGH_EN
              r_op    <= mul_op_t'(i_op);
`endif
            end else begin
              r_state <= IDLE;
            end
          end
          ISSUE: begin
            if (r_idx == w_last_idx) begin
              r_drain <= 2'(LAT - 1);
              r_state <= DRAIN;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
          DRAIN: begin
            if (r_drain == 2'd0) begin
`ifdef NIOS2_MUL_HIGH_EN
              if (r_op != MUL) begin
                r_state <= CORR;
              end else
`endif
              begin
                o_result <= w_acc_next[31:0];
                o_done   <= 1'b1;
                o_busy   <= 1'b0;
                r_state  <= DONE;
              end
            end else begin
              r_drain <= r_drain - 2'd1;
            end
          end
`ifdef NIOS2_MUL_HIGH_EN
          CORR: begin
            o_result <= w_hi;
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            r_state  <= DONE;
          end
`endif
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios2_mul_seq.sv
module tb_nios2_mul_seq;

  localparam int LAT = 1;
`ifdef NIOS2_MUL_HIGH_EN
  localparam bit HIGH = 1'b1;
`else
  localparam bit HIGH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios2_mul_seq #(.LAT(LAT)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_en      (en),
    .i_start   (start),
    .i_op      (op),
    .i_src1    (src1),
    .i_src2    (src2),
    .o_busy    (busy),
    .o_done    (done),
    .o_result  (result)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference: full-width product with operands extended per signedness.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'd0, a};
    eb = {32'd0, b};
    if (!HIGH || o == 2'b00) begin
      p = ea * eb;
      return p[31:0];
    end
    if (o == 2'b01 || o == 2'b10) ea = {{32{a[31]}}, a};
    if (o == 2'b01)               eb = {{32{b[31]}}, b};
    p = ea * eb;
    return p[63:32];
  endfunction

  function automatic int ref_lat(input logic [1:0] o);
    if (HIGH && o != 2'b00) return 4 + LAT + 1;
    return 3 + LAT;
  endfunction

  // Called with time just after an edge or at a negedge; returns #1 after accept edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int fz_at, input int fz_len,
                           input bit poke);
    int cyc = 0;
    bit seen = 1'b0;
    while (cyc < 60 && !seen) begin
      if (fz_len > 0 && cyc == fz_at)          en = 1'b0;
      if (fz_len > 0 && cyc == fz_at + fz_len) en = 1'b1;
      if (poke && cyc == 1) begin
        start = 1'b1; op = 2'b11; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678;
      end
      if (poke && cyc == 2) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    en = 1'b1;
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(ref_lat(o) + fz_len));
    chk({tag, "_result"}, result, ref_mul(o, a, b));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int fz_at, input int fz_len,
                     input bit poke, input bit chain);
    if (!chain) @(negedge clk);
    launch(o, a, b);
    wait_done(tag, o, a, b, fz_at, fz_len, poke);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);

    run("mul_basic", 2'b00, 32'h0001_0003, 32'h0002_0005, 0, 0, 1'b0, 1'b0);
    run("mulxuu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    run("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    run("mulxss_m1x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 1'b0, 1'b0);
    run("mulxss_m1xm1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    run("mulxsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    run("mulxuu_small", 2'b11, 32'h0001_0003, 32'h0002_0005, 0, 0, 1'b0, 1'b0);

    // en low for two cycles during ISSUE, plus a start while busy
    run("mul_freeze", 2'b00, 32'h0001_0003, 32'h0002_0005, 1, 2, 1'b1, 1'b0);
    held = result;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("result_held", result, held);

    // reset while draining discards the operation
    @(negedge clk);
    launch(2'b11, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (HIGH ? 4 : 3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midop_reset_busy", 32'(busy), 32'd0);
    chk("midop_reset_done", 32'(done), 32'd0);
    chk("midop_reset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run("mul_3x5", 2'b00, 32'd3, 32'd5, 0, 0, 1'b0, 1'b0);
    run("b2b_mulxss", 2'b01, 32'h8000_0001, 32'h7FFF_FFFF, 0, 0, 1'b0, 1'b1);
    run("b2b_mul", 2'b00, 32'hCAFE_F00D, 32'h0BAD_BEEF, 0, 0, 1'b0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  r_o;
      logic [31:0] r_a, r_b;
      int fl;
      r_o = 2'($urandom_range(0, 3));
      r_a = pick_val();
      r_b = pick_val();
      fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run($sformatf("rand%0d", k), r_o, r_a, r_b, $urandom_range(1, 3), fl,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
